wb_mul_requester: RTL
=====================

Name: wb_mul_requester

Overview:
- Wishbone-mapped front end for the pipelined multiplier.
- Lets the management core write two 32-bit operands and start an operation. The block then drives the multiplier's enq handshake, drains its deq port, and holds the 64-bit product for readback.
- It is the requesting end of the multiplier enq/deq interface, replacing logic-analyzer-driven stimulus with a register interface plus interrupt.

Parameters:
- ADDR_BASE, 24'h300000, compared against wbs_adr_i[31:8] for block select.
- TIMEOUT_CYCLES, 255, maximum cycles from entering ISSUE to deq handshake before abort (range 1..65535).

Ports:
- clock  in  1  single block clock (wb_clk_i at top level)
- reset_n  in  1  asynchronous, active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte lane select
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- io_enq_valid  out  1  request valid to multiplier
- io_enq_ready  in  1  multiplier accepts request
- io_op1  out  32  operand 1, stable while io_enq_valid is high
- io_op2  out  32  operand 2, stable while io_enq_valid is high
- io_deq_valid  in  1  product valid
- io_deq_ready  out  1  ready to take product
- io_res  in  64  product
- io_flush  out  1  one-cycle abort pulse to multiplier
- irq  out  1  done interrupt, level

Behaviour:
- Reset: clock, asynchronous active-low reset_n.
  - All registers, FSM state and outputs go to 0 immediately on reset_n low; FSM state is IDLE.
  - An in-flight request is dropped with no flush; the multiplier shares the reset.
- Wishbone access:
  - Access occurs when cyc & stb & adr[31:8]==ADDR_BASE.
  - wbs_ack_o pulses high one cycle after the access and is forced low the following cycle, so a held strobe yields one ack per two cycles.
  - Reads of unmapped offsets return 0; writes to them are dropped.
- Register map, selected by adr[4:2]:
  - 0x00 OP1: rw, byte-lane writes per wbs_sel_i.
  - 0x04 OP2: rw, byte-lane writes per wbs_sel_i.
  - 0x08 CTRL/STAT.
    - Write, acted on only when sel[0]=1: b0 START (pulse); b1 DONE W1C; b2 OVR W1C; b3 TMO W1C; b4 IE rw.
    - Read: b0 BUSY, b1 DONE, b2 OVR, b3 TMO, b4 IE, b31:5 zero.
  - 0x0C RES_LO: ro, product bits [31:0].
  - 0x10 RES_HI: ro, product bits [63:32].
  - 0x14 LAT: see Optional Feature.
- FSM IDLE → ISSUE → WAIT → IDLE:
  - IDLE: START copies OP1/OP2 into shadow registers, clears DONE, clears timeout counter, goes to ISSUE. BUSY = (state != IDLE).
  - ISSUE: io_enq_valid=1, io_op1/io_op2 driven from the shadow registers. On enq_valid & enq_ready, go to WAIT. Operands never change while io_enq_valid is high.
  - WAIT: io_deq_ready=1. On deq_valid & deq_ready, capture io_res into RES, set DONE, go to IDLE.
- Timeout:
  - The counter runs during ISSUE and WAIT.
  - When it reaches TIMEOUT_CYCLES with no deq handshake: io_flush=1 for exactly one cycle, TMO set, DONE not set, RES unchanged, go to IDLE.
  - If the deq handshake and the timeout occur in the same cycle, the handshake wins and there is no flush.
- START while BUSY: ignored, OVR set; the in-flight operation is unaffected.
- START and DONE-W1C in the same write: DONE ends at 0 and the operation starts.
- OP writes while BUSY: allowed; they affect only the next START.
- irq = DONE & IE, registered.
- Latency: an operation takes 1 cycle to enter ISSUE, plus the multiplier latency, plus 1 cycle to set DONE.

Optional Feature:
- Macro: MUL_LATENCY_CNT_EN.
- Defined: a 16-bit counter clears on START and increments each cycle in ISSUE/WAIT, saturating at 0xFFFF. On deq handshake it is copied to LAT (0x14, ro, upper bits 0). It is not updated on timeout.
- Undefined: no counter logic; 0x14 reads 0 like any unmapped offset.

Decomposition:
- Shared package wb_mul_pkg:
  - register offset constants (OFF_OP1..OFF_LAT)
  - CTRL bit index constants
  - FSM state enum (IDLE, ISSUE, WAIT)
  - RES_W=64 and OP_W=32
- One sub-module: wb_mul_regs. It holds Wishbone decode, ack generation, register file and read mux, and exports START / W1C pulses.
- The FSM, shadow registers and timeout counter stay in the top module.

Test Plan:
- Basic: write OP1=0x0000_FFFF, OP2=0x0001_0000, START; multiplier model takes 3 cycles → DONE=1, RES_HI=0x0, RES_LO=0xFFFF_0000, BUSY=0.
- Backpressure: hold io_enq_ready low 10 cycles while changing OP1 → io_op1/io_op2 stable throughout; product uses operands captured at START.
- Overrun: START, then START again while BUSY → OVR=1, exactly one enq handshake; writing CTRL=0x4 clears OVR.
- Timeout: TIMEOUT_CYCLES=8, model never asserts deq_valid → io_flush high for exactly 1 cycle, TMO=1, DONE=0, state IDLE.
- Interrupt: IE=1, run op 0xFFFF_FFFF×0xFFFF_FFFF → RES=0xFFFF_FFFE_0000_0001, irq=1; writing CTRL=0x12 (DONE W1C, IE kept) → irq=0 next cycle.
- Reset mid-operation: drop reset_n during WAIT → io_enq_valid, io_deq_ready, io_flush, irq and wbs_ack_o go to 0 immediately; all registers read 0 after release.

Source files
------------

// File: rtl/wb_mul_pkg.sv
// Shared definitions for the Wishbone multiplier requester: register
// offsets, CTRL/STAT bit positions, FSM states and datapath widths.
package wb_mul_pkg;

    localparam int OP_W  = 32;
    localparam int RES_W = 64;

    // Byte offsets inside the block, decoded from wbs_adr_i[4:2].
    localparam logic [4:0] OFF_OP1    = 5'h00;
    localparam logic [4:0] OFF_OP2    = 5'h04;
    localparam logic [4:0] OFF_CTRL   = 5'h08;
    localparam logic [4:0] OFF_RES_LO = 5'h0C;
    localparam logic [4:0] OFF_RES_HI = 5'h10;
    localparam logic [4:0] OFF_LAT    = 5'h14;

    // CTRL write bits; on read bit 0 is BUSY and the rest line up.
    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_OVR   = 2;
    localparam int CTRL_TMO   = 3;
    localparam int CTRL_IE    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/wb_mul_if.sv
// Bus bundles for the requester: the Wishbone slave port towards the
// management core and the enq/deq handshake towards the multiplier.
interface wb_mul_wb_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

interface wb_mul_io_if;
    import wb_mul_pkg::*;
    logic             io_enq_valid;
    logic             io_enq_ready;
    logic [OP_W-1:0]  io_op1;
    logic [OP_W-1:0]  io_op2;
    logic             io_deq_valid;
    logic             io_deq_ready;
    logic [RES_W-1:0] io_res;
    logic             io_flush;

    // The requester is the master; the multiplier is the slave.
    modport master (
        output io_enq_valid, io_op1, io_op2, io_deq_ready, io_flush,
        input  io_enq_ready, io_deq_valid, io_res
    );
    modport slave (
        input  io_enq_valid, io_op1, io_op2, io_deq_ready, io_flush,
        output io_enq_ready, io_deq_valid, io_res
    );
endinterface

// File: rtl/wb_mul_regs.sv
// Wishbone decode, ack generation, register file and read mux for the
// multiplier requester. Exports the START and W1C pulses to the FSM.
// Optional: MUL_LATENCY_CNT_EN adds the read-only LAT register at 0x14.
module wb_mul_regs
    import wb_mul_pkg::*;
#(
    parameter logic [23:0] ADDR_BASE = 24'h300000
) (
    input  logic             clock,
    input  logic             reset_n,
    wb_mul_wb_if.slave       wb,
    input  logic             busy,
    input  logic             done,
    input  logic             ovr,
    input  logic             tmo,
    input  logic             res_load,
    input  logic [RES_W-1:0] res_in,
`ifdef MUL_LATENCY_CNT_EN
    input  logic             lat_load,
    input  logic [15:0]      lat_in,
`endif
    output logic             start,
    output logic             clr_done,
    output logic             clr_ovr,
    output logic             clr_tmo,
    output logic             ie,
    output logic [OP_W-1:0]  op1,
    output logic [OP_W-1:0]  op2
);

    logic             ack_q;
    logic [31:0]      dat_q;
    logic [31:0]      rdata;
    logic             hit, acc, wr, ctrl_wr;
    logic [4:0]       off;
    logic [RES_W-1:0] res_q;
`ifdef MUL_LATENCY_CNT_EN
    logic [15:0]      lat_q;
`endif

    // Address bits outside the decoded window alias onto the map.
    logic unused_adr;
    assign unused_adr = &{1'b0, wb.wbs_adr_i[7:5], wb.wbs_adr_i[1:0]};

    // An access is taken only while ack is low, giving one ack per two
    // cycles on a held strobe.
    assign hit     = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == ADDR_BASE);
    assign acc     = hit & ~ack_q;
    assign wr      = acc & wb.wbs_we_i;
    assign off     = {wb.wbs_adr_i[4:2], 2'b00};
    assign ctrl_wr = wr & (off == OFF_CTRL) & wb.wbs_sel_i[0];

    assign start    = ctrl_wr & wb.wbs_dat_i[CTRL_START];
    assign clr_done = ctrl_wr & wb.wbs_dat_i[CTRL_DONE];
    assign clr_ovr  = ctrl_wr & wb.wbs_dat_i[CTRL_OVR];
    assign clr_tmo  = ctrl_wr & wb.wbs_dat_i[CTRL_TMO];

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

    // Read mux over the register map.
    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch is inferred.
        rdata = '0;
        case (off)
            OFF_OP1:    rdata = op1;
            OFF_OP2:    rdata = op2;
            OFF_CTRL:   rdata = {27'd0, ie, tmo, ovr, done, busy};
            OFF_RES_LO: rdata = res_q[31:0];
            OFF_RES_HI: rdata = res_q[63:32];
`ifdef MUL_LATENCY_CNT_EN
            OFF_LAT:    rdata = {16'd0, lat_q};
`else
            OFF_LAT:    rdata = '0;
`endif
            default:    rdata = '0;
        endcase
    end

    // Ack pulse and registered read data, zero outside the ack cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc;
            dat_q <= (acc & ~wb.wbs_we_i) ? rdata : '0;
        end
    end

    // Writable registers and the captured product.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op1   <= '0;
            op2   <= '0;
            ie    <= 1'b0;
            res_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr && off == OFF_OP1 && wb.wbs_sel_i[i])
                    op1[8*i +: 8] <= wb.wbs_dat_i[8*i +: 8];
                if (wr && off == OFF_OP2 && wb.wbs_sel_i[i])
                    op2[8*i +: 8] <= wb.wbs_dat_i[8*i +: 8];
            end
            if (ctrl_wr)
                ie <= wb.wbs_dat_i[CTRL_IE];
            if (res_load)
                res_q <= res_in;
        end
    end

`ifdef MUL_LATENCY_CNT_EN
    // Latency snapshot taken on each completed operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            lat_q <= '0;
        else if (lat_load)
            lat_q <= lat_in;
    end
`endif

endmodule

// File: rtl/wb_mul_requester.sv
// Wishbone-mapped requester for the pipelined multiplier: latches
// operands on START, drives enq, drains deq, aborts with a flush pulse
// on timeout and raises a level interrupt on completion.
// Optional: MUL_LATENCY_CNT_EN enables the busy-cycle latency counter.
module wb_mul_requester
    import wb_mul_pkg::*;
#(
    parameter logic [23:0] ADDR_BASE      = 24'h300000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    wb_mul_wb_if.slave  wb,
    wb_mul_io_if.master mul,
    output logic        irq
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [OP_W-1:0] op1_sh, op2_sh;
    logic [15:0]     tmo_cnt;
    logic            enq_valid_q, deq_ready_q, flush_q;
    logic            done_q, ovr_q, tmo_q, irq_q;

    logic            start, clr_done, clr_ovr, clr_tmo, ie;
    logic [OP_W-1:0] op1, op2;
    logic            busy, start_go, enq_fire, deq_fire, tmo_hit;

    assign busy     = (state != IDLE);
    assign start_go = start & ~busy;
    assign enq_fire = enq_valid_q & mul.io_enq_ready;
    assign deq_fire = deq_ready_q & mul.io_deq_valid;
    // A deq handshake in the final cycle beats the timeout.
    assign tmo_hit  = busy & (tmo_cnt == TMO_LAST) & ~deq_fire;

    assign mul.io_enq_valid = enq_valid_q;
    assign mul.io_deq_ready = deq_ready_q;
    assign mul.io_op1       = op1_sh;
    assign mul.io_op2       = op2_sh;
    assign mul.io_flush     = flush_q;
    assign irq              = irq_q;

`ifdef MUL_LATENCY_CNT_EN
    logic [15:0] lat_cnt;
    logic [15:0] lat_final;
    assign lat_final = sat_inc16(lat_cnt);

    // Busy-cycle count of the current operation, saturating.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            lat_cnt <= '0;
        else if (start_go)
            lat_cnt <= '0;
        else if (busy)
            lat_cnt <= sat_inc16(lat_cnt);
    end
`endif

    wb_mul_regs #(
        .ADDR_BASE (ADDR_BASE)
    ) u_regs (
        .clock    (clock),
        .reset_n  (reset_n),
        .wb       (wb),
        .busy     (busy),
        .done     (done_q),
        .ovr      (ovr_q),
        .tmo      (tmo_q),
        .res_load (deq_fire),
        .res_in   (mul.io_res),
`ifdef MUL_LATENCY_CNT_EN
        .lat_load (deq_fire),
        .lat_in   (lat_final),
`endif
        .start    (start),
        .clr_done (clr_done),
        .clr_ovr  (clr_ovr),
        .clr_tmo  (clr_tmo),
        .ie       (ie),
        .op1      (op1),
        .op2      (op2)
    );

    // Request FSM with registered handshake outputs and timeout abort.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            op1_sh      <= '0;
            op2_sh      <= '0;
            tmo_cnt     <= '0;
            enq_valid_q <= 1'b0;
            deq_ready_q <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_go) begin
                        op1_sh      <= op1;
                        op2_sh      <= op2;
                        tmo_cnt     <= '0;
                        enq_valid_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tmo_hit) begin
                        enq_valid_q <= 1'b0;
                        flush_q     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                        if (enq_fire) begin
                            enq_valid_q <= 1'b0;
                            deq_ready_q <= 1'b1;
                            state       <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (deq_fire) begin
                        deq_ready_q <= 1'b0;
                        state       <= IDLE;
                    end else if (tmo_hit) begin
                        deq_ready_q <= 1'b0;
                        flush_q     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky status flags and the registered interrupt.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            tmo_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (clr_done || start_go) done_q <= 1'b0;
            if (deq_fire)             done_q <= 1'b1;
            if (clr_ovr)              ovr_q  <= 1'b0;
            if (start && busy)        ovr_q  <= 1'b1;
            if (clr_tmo)              tmo_q  <= 1'b0;
            if (tmo_hit)              tmo_q  <= 1'b1;
            irq_q <= done_q & ie;
        end
    end

endmodule
